// File: rtl/jtframe_dual_ram_be.sv
// Single-clock true dual-port RAM with per-byte write enables, selectable
// read-during-write behaviour and a built-in clear sequencer. The sequencer
// owns the memory after reset or a clr request. It fills every word with
// clrval and then hands the memory to the two ports.
module jtframe_dual_ram_be #(
    parameter int unsigned     dw     = 16,
    parameter int unsigned     aw     = 10,
    parameter int unsigned     wrmode = 0,
    parameter logic [dw-1:0]   clrval = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    // port 0
    input  logic [dw-1:0]     data0,
    input  logic [aw-1:0]     addr0,
    input  logic [dw/8-1:0]   we0,
    output logic [dw-1:0]     q0,
    // port 1
    input  logic [dw-1:0]     data1,
    input  logic [aw-1:0]     addr1,
    input  logic [dw/8-1:0]   we1,
    output logic [dw-1:0]     q1
);

    localparam int unsigned bw = dw / 8;

    // Parameter sanity, caught at elaboration time.
    if ((dw % 8) != 0 || dw == 0) begin : g_bad_dw
        $fatal(1, "jtframe_dual_ram_be: dw=%0d is not a non-zero multiple of 8", dw);
    end
    if (wrmode > 1) begin : g_bad_wrmode
        $fatal(1, "jtframe_dual_ram_be: wrmode=%0d out of range (0 or 1)", wrmode);
    end

    typedef enum logic {
        StClear,
        StRun
    } state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [aw-1:0]     r_cnt;
    logic [aw-1:0]     w_cnt_next;

    logic [dw-1:0]     r_mem [2**aw];
    logic [dw-1:0]     r_q0;
    logic [dw-1:0]     r_q1;

    logic              w_run;
    logic [bw-1:0]     w_we0;
    logic [bw-1:0]     w_we1;
    logic              w_same_addr;
    logic [dw-1:0]     w_old0;
    logic [dw-1:0]     w_old1;
    logic [dw-1:0]     w_new0;
    logic [dw-1:0]     w_new1;
    logic [dw-1:0]     w_rd0;
    logic [dw-1:0]     w_rd1;

    // Word as it will stand after this cycle's writes: port 1 lanes first,
    // then port 0 lanes on top so port 0 wins a shared lane.
    function automatic logic [dw-1:0] f_merge(
        input logic [dw-1:0] base,
        input logic          hit1,
        input logic [bw-1:0] be1,
        input logic [dw-1:0] d1,
        input logic          hit0,
        input logic [bw-1:0] be0,
        input logic [dw-1:0] d0
    );
        logic [dw-1:0] word;
        word = base;
        for (int i = 0; i < bw; i++) begin
            if (hit1 && be1[i]) begin
                word[8*i +: 8] = d1[8*i +: 8];
            end
            if (hit0 && be0[i]) begin
                word[8*i +: 8] = d0[8*i +: 8];
            end
        end
        return word;
    endfunction

    assign w_run       = (r_state == StRun);
    assign busy        = (r_state == StClear);
    assign w_we0       = w_run ? we0 : '0;
    assign w_we1       = w_run ? we1 : '0;
    assign w_same_addr = (addr0 == addr1);

    // Sequencer next state: clr always restarts the fill from address 0.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            StClear: begin
                if (clr) begin
                    w_cnt_next = '0;
                end else begin
                    // Counter wraps to 0 naturally after the last address.
                    w_cnt_next = r_cnt + 1'b1;
                    if (&r_cnt) begin
                        w_state_next = StRun;
                    end
                end
            end
            StRun: begin
                if (clr) begin
                    w_state_next = StClear;
                    w_cnt_next   = '0;
                end
            end
        endcase
    end

    // Sequencer state and clear address registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StClear;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Memory array: clear fill while busy, byte-lane port writes otherwise.
    // Port 0 is written last so it owns lanes both ports enable.
    always_ff @(posedge clk) begin
        if (!w_run) begin
            r_mem[r_cnt] <= clrval;
        end else begin
            for (int i = 0; i < bw; i++) begin
                if (w_we1[i]) begin
                    r_mem[addr1][8*i +: 8] <= data1[8*i +: 8];
                end
                if (w_we0[i]) begin
                    r_mem[addr0][8*i +: 8] <= data0[8*i +: 8];
                end
            end
        end
    end

    // Read-side words: stored content and content after this cycle's writes.
    always_comb begin
        w_old0 = r_mem[addr0];
        w_old1 = r_mem[addr1];
        w_new0 = f_merge(w_old0, w_same_addr, w_we1, data1, 1'b1, w_we0, data0);
        w_new1 = f_merge(w_old1, 1'b1, w_we1, data1, w_same_addr, w_we0, data0);
        w_rd0  = (wrmode == 1) ? w_new0 : w_old0;
        w_rd1  = (wrmode == 1) ? w_new1 : w_old1;
    end

    // Registered read data, forced to zero while the sequencer owns memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q0 <= '0;
            r_q1 <= '0;
        end else if (!w_run) begin
            r_q0 <= '0;
            r_q1 <= '0;
        end else begin
            r_q0 <= w_rd0;
            r_q1 <= w_rd1;
        end
    end

    assign q0 = r_q0;
    assign q1 = r_q1;

endmodule

// File: tb/tb_jtframe_dual_ram_be.sv
// Bench for jtframe_dual_ram_be. Two instances (read-first and write-first)
// share the same stimulus. A word-level model predicts busy and read data
// every cycle, and directed steps pin the model with hand-computed values.
module tb_jtframe_dual_ram_be;

    localparam logic [15:0] CLR = 16'hA5A5;

    logic        clk;
    logic        rst;
    logic        clr;
    logic [15:0] data0, data1;
    logic [3:0]  addr0, addr1;
    logic [1:0]  we0, we1;
    logic        busy_a, busy_b;
    logic [15:0] q0_a, q1_a, q0_b, q1_b;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 0;

    jtframe_dual_ram_be #(.dw(16), .aw(4), .wrmode(0), .clrval(CLR)) u_dut_a (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_a),
        .data0(data0), .addr0(addr0), .we0(we0), .q0(q0_a),
        .data1(data1), .addr1(addr1), .we1(we1), .q1(q1_a)
    );

    jtframe_dual_ram_be #(.dw(16), .aw(4), .wrmode(1), .clrval(CLR)) u_dut_b (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy_b),
        .data0(data0), .addr0(addr0), .we0(we0), .q0(q0_b),
        .data1(data1), .addr1(addr1), .we1(we1), .q1(q1_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // clear_left counts remaining busy edges; the whole array becomes CLR
    // when the fill completes (reads are zero while busy, so the order of
    // the fill is not observable).
    logic [15:0] m_mem [16];
    int          clear_left = 16;
    logic [15:0] e_q0_old = '0, e_q1_old = '0, e_q0_new = '0, e_q1_new = '0;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                clear_left = 16;
                e_q0_old = '0; e_q1_old = '0; e_q0_new = '0; e_q1_new = '0;
            end else if (clear_left > 0) begin
                e_q0_old = '0; e_q1_old = '0; e_q0_new = '0; e_q1_new = '0;
                if (clr) begin
                    clear_left = 16;
                end else begin
                    clear_left--;
                    if (clear_left == 0) begin
                        for (int i = 0; i < 16; i++) m_mem[i] = CLR;
                    end
                end
            end else begin
                e_q0_old = m_mem[addr0];
                e_q1_old = m_mem[addr1];
                for (int l = 0; l < 2; l++) begin
                    if (we1[l]) m_mem[addr1][8*l +: 8] = data1[8*l +: 8];
                end
                for (int l = 0; l < 2; l++) begin
                    if (we0[l]) m_mem[addr0][8*l +: 8] = data0[8*l +: 8];
                end
                e_q0_new = m_mem[addr0];
                e_q1_new = m_mem[addr1];
                if (clr) clear_left = 16;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                check("busy_a", {15'd0, busy_a}, {15'd0, clear_left != 0});
                check("busy_b", {15'd0, busy_b}, {15'd0, clear_left != 0});
                check("q0_rdfirst", q0_a, e_q0_old);
                check("q1_rdfirst", q1_a, e_q1_old);
                check("q0_wrfirst", q0_b, e_q0_new);
                check("q1_wrfirst", q1_b, e_q1_new);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input logic [3:0] a0, input logic [15:0] d0, input logic [1:0] w0,
                         input logic [3:0] a1, input logic [15:0] d1, input logic [1:0] w1);
        addr0 = a0; data0 = d0; we0 = w0;
        addr1 = a1; data1 = d1; we1 = w1;
        clr   = 1'b0;
        @(negedge clk);
    endtask

    // Counts negedges until busy drops, starting from the current negedge.
    task automatic count_busy(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy_a && n < 100);
    endtask

    task automatic sweep(input string tag);
        for (int i = 0; i < 16; i++) begin
            drive(4'(i), 16'h0, 2'b00, 4'(15 - i), 16'h0, 2'b00);
            check({tag, "_q0a"}, q0_a, CLR);
            check({tag, "_q1a"}, q1_a, CLR);
            check({tag, "_q0b"}, q0_b, CLR);
            check({tag, "_q1b"}, q1_b, CLR);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1; clr = 1'b0;
        addr0 = '0; data0 = '0; we0 = '0;
        addr1 = '0; data1 = '0; we1 = '0;
        repeat (3) @(negedge clk);
        cmp_en = 1;
        check("rst_busy", {15'd0, busy_a}, 16'd1);
        check("rst_q0", q0_a, 16'h0000);
        check("rst_q1b", q1_b, 16'h0000);

        // Clear after reset: 16 busy cycles, then every word reads CLR.
        rst = 1'b0;
        count_busy(n);
        check("clear_len", 16'(n), 16'd16);
        sweep("clear");

        // Byte-lane write: 1234 then FF56 on the upper lane only.
        drive(4'd3, 16'h1234, 2'b11, 4'd0, 16'h0, 2'b00);
        drive(4'd3, 16'hFF56, 2'b10, 4'd0, 16'h0, 2'b00);
        drive(4'd0, 16'h0, 2'b00, 4'd3, 16'h0, 2'b00);
        check("lane_q1a", q1_a, 16'hFF34);
        check("lane_q1b", q1_b, 16'hFF34);

        // Read during write at addr 5, same port and cross port.
        drive(4'd5, 16'h0001, 2'b11, 4'd0, 16'h0, 2'b00);
        drive(4'd5, 16'h0002, 2'b11, 4'd5, 16'h0, 2'b00);
        check("rdw_q0_old", q0_a, 16'h0001);
        check("rdw_q1_old", q1_a, 16'h0001);
        check("rdw_q0_new", q0_b, 16'h0002);
        check("rdw_q1_new", q1_b, 16'h0002);

        // Write collision at addr 7: port 0 owns lane 0, port 1 lane 1.
        drive(4'd7, 16'hAAAA, 2'b01, 4'd7, 16'hBBBB, 2'b11);
        check("coll_q0_old", q0_a, CLR);
        check("coll_q0_new", q0_b, 16'hBBAA);
        check("coll_q1_new", q1_b, 16'hBBAA);
        drive(4'd7, 16'h0, 2'b00, 4'd7, 16'h0, 2'b00);
        check("coll_rd_a", q0_a, 16'hBBAA);
        check("coll_rd_b", q1_b, 16'hBBAA);

        // Mixed traffic on a few addresses to provoke overlaps.
        for (int k = 0; k < 60; k++) begin
            drive(4'($urandom_range(0, 3)), 16'($urandom), 2'($urandom),
                  4'($urandom_range(0, 3)), 16'($urandom), 2'($urandom));
        end

        // clr in RUN, with port writes held on addr 3 for the whole clear.
        addr0 = 4'd0; we0 = 2'b00; we1 = 2'b00; clr = 1'b1;
        @(negedge clk);
        check("clr_busy_rise", {15'd0, busy_a}, 16'd1);
        clr = 1'b0; addr0 = 4'd3; data0 = 16'h1111; we0 = 2'b11;
        addr1 = 4'd9; data1 = 16'h2222; we1 = 2'b11;
        count_busy(n);
        we0 = 2'b00; we1 = 2'b00;
        check("clr_len", 16'(n), 16'd16);
        drive(4'd3, 16'h0, 2'b00, 4'd9, 16'h0, 2'b00);
        check("clr_addr3", q0_a, CLR);
        check("clr_addr9", q1_b, CLR);

        // Dirty a word, start a clear, then reset at cycle 8 of it.
        drive(4'd2, 16'h5A5A, 2'b11, 4'd0, 16'h0, 2'b00);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_busy", {15'd0, busy_b}, 16'd1);
        rst = 1'b0;
        count_busy(n);
        check("rst_mid_len", 16'(n), 16'd16);
        sweep("rst_mid");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/jtframe_dual_ram_be.md
Name: jtframe_dual_ram_be

Overview:
Single-clock true dual-port RAM for game cores.
- Generalises the existing dual-port RAM with per-byte write enables and a selectable read-during-write mode.
- Defines a rule for simultaneous writes from both ports.
- Includes a built-in clear sequencer that fills memory with a constant after reset or on request.
- Sits between CPU and video/sound engines as shared work/palette/object RAM, which must start zeroed on every core reset.

Parameters:
- dw, 16, data width in bits; must be a multiple of 8.
- aw, 10, address width; depth is 2**aw words.
- wrmode, 0, read-during-write mode: 0 = old data (read-first), 1 = new data (write-first bypass). Applies to the same port and across ports.
- clrval, 0, dw-bit value written to every word by the clear sequencer.
- Localparam bw = dw/8, the number of byte lanes.

Ports:
- clk  in  1  single clock for both ports and the sequencer.
- rst  in  1  asynchronous, active-high reset.
- clr  in  1  one-cycle request to restart the clear sequence.
- busy  out  1  high while the clear sequencer owns the memory.
- data0  in  dw  port 0 write data.
- addr0  in  aw  port 0 address.
- we0  in  bw  port 0 byte write enables; bit i covers data0[8i+7:8i].
- q0  out  dw  port 0 registered read data.
- data1  in  dw  port 1 write data.
- addr1  in  aw  port 1 address.
- we1  in  bw  port 1 byte write enables.
- q1  out  dw  port 1 registered read data.

Behaviour:
- Reset (async assert):
  - q0 = q1 = 0, busy = 1.
  - Clear counter = 0, state = CLEAR.
  - Memory contents are not reset asynchronously; the sequencer clears them.
- FSM has two states, CLEAR and RUN.
- CLEAR state:
  - Each clk writes clrval to mem[cnt], then cnt increments.
  - After the write of address 2**aw-1, next state is RUN, busy = 0 and cnt wraps to 0.
  - Exactly 2**aw cycles with busy = 1 after rst deasserts.
  - clr asserted during CLEAR restarts: cnt = 0 on the next edge, and busy stays high.
- RUN state: clr = 1 moves to CLEAR with cnt = 0; busy goes high on the next edge.
- While busy:
  - we0/we1 are ignored.
  - q0 and q1 register 0 each cycle.
- Reads in RUN:
  - 1-cycle latency: addrN sampled at edge k, qN valid after edge k.
  - qN is registered every cycle; there is no enable.
- Byte writes in RUN: only the lanes with weN[i] = 1 update; the other lanes keep their prior content.
- Same-port read-during-write:
  - wrmode 0: qN = content before the write.
  - wrmode 1: qN = merged word, with new bytes in enabled lanes and old bytes elsewhere.
- Cross-port, same address, one port writing and the other reading:
  - wrmode 0: the reader gets old data.
  - wrmode 1: the reader gets the merged new data.
- Both ports writing the same address in the same cycle:
  - Each lane enabled by both ports takes data0 (port 0 wins).
  - Lanes enabled by only one port take that port's data.
  - In wrmode 1, both q0 and q1 show the final merged word.
- Different addresses: the two ports are fully independent, with no stalls.
- Reset mid-CLEAR or mid-RUN: the FSM returns to CLEAR with cnt = 0, and the full clear repeats.
- Simulation only: an out-of-range wrmode or a dw not multiple of 8 triggers $display of an error and $finish.

Test Plan:
- Clear after reset (aw=4, clrval=16'hA5A5, rst pulsed):
  - busy high for exactly 16 clk after rst falls.
  - Afterwards, reads of addresses 0..15 on both ports return 16'hA5A5.
- Byte-lane write (dw=16):
  - Write 16'h1234 with we0=2'b11 to addr 3, then 16'hFFxx with we0=2'b10.
  - A read of addr 3 on port 1 returns 16'hFF34.
- Read-during-write (addr 5 holding 16'h0001, port 0 writes 16'h0002 while port 1 reads addr 5):
  - wrmode 0: q0 = q1 = 16'h0001.
  - wrmode 1: q0 = q1 = 16'h0002.
- Write collision at addr 7:
  - Inputs: data0 = 16'hAAAA with we0 = 2'b01; data1 = 16'hBBBB with we1 = 2'b11.
  - A later read returns 16'hBBAA.
- clr mid-operation:
  - clr pulsed in RUN: busy rises next cycle and stays high 2**aw cycles.
  - A port write issued while busy does not persist: the word reads clrval afterwards.
- Reset mid-clear:
  - Assert rst at cycle 8 of a clear; release it.
  - busy then stays high a full 16 cycles, and all words read clrval.
